// File: rtl/mult_iter.sv
// mult_iter: iterative radix-2 shift-add multiplier, signed or unsigned.
//
// One multiplier bit is retired per cycle on magnitudes, and the sign is
// applied once when the product is published. A start in IDLE is sampled at
// edge k. The product appears on z at edge k+WIDTH+1, and done pulses in the
// cycle after that edge.
//
// Configuration macro:
//   MULT_ZERO_BYPASS_EN - a zero operand skips RUN and goes straight to DONE.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   start in   request a multiply (sampled only in IDLE)
//   sign  in   1 = two's-complement operands, 0 = unsigned
//   a, b  in   multiplicand / multiplier, WIDTH bits
//   busy  out  state is not IDLE
//   done  out  one-cycle pulse, z just updated
//   z     out  2*WIDTH product register, held until next completion
module mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;       // result polarity; sign itself is not kept
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               done_q, done_d;

  // Negating -2^(WIDTH-1) gives back the same bit pattern. Read as unsigned,
  // that pattern is the correct magnitude 2^(WIDTH-1), so no extra bit is needed.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    z_d      = z_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef MULT_ZERO_BYPASS_EN
          // The accumulator was just cleared, so DONE publishes a zero.
          if (a == '0 || b == '0) state_d = DONE;
`endif
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        z_d     = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      z_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: tb/tb_mult_iter.sv
// Self-checking bench for mult_iter (WIDTH=32 plus a WIDTH=8 instance).
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sign;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] z;

  logic        start8, sign8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] z8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .a(a), .b(b),
    .busy(busy), .done(done), .z(z)
  );

  mult_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .z(z8)
  );

  // Reference: exact integer product, truncated to 2*WIDTH bits.
  function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint ex, ey;
    ex = s ? longint'($signed(x)) : longint'({32'b0, x});
    ey = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(ex * ey);
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    int ex, ey;
    ex = s ? int'($signed(x)) : int'({24'b0, x});
    ey = s ? int'($signed(y)) : int'({24'b0, y});
    return 16'(ex * ey);
  endfunction

  // Edges from the start-sampling edge to the edge after which done is high.
  function automatic int lat_exp(input int w, input logic zero);
`ifdef MULT_ZERO_BYPASS_EN
    return zero ? 1 : w + 1;
`else
    return zero ? w + 1 : w + 1;
`endif
  endfunction

  // Runs one WIDTH=32 op and scrambles the inputs after the start edge.
  // lat stays -1 if done never arrives.
  task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] zr, output int lat);
    start = 1'b1; sign = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; sign = 1'($urandom); a = $urandom; b = $urandom;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    zr = z;
  endtask

  task automatic run_op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] zr, output int lat);
    start8 = 1'b1; sign8 = s; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; sign8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
    end
    zr = z8;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (z !== 64'd0) begin bad++; $display("FAIL reset_z got=%h exp=0", z); end
    total++; if (z8 !== 16'd0 || busy8 !== 1'b0) begin bad++; $display("FAIL reset_w8 z=%h busy=%b exp=0/0", z8, busy8); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || z !== 64'd0) begin
      bad++; $display("FAIL post_reset_idle busy=%b done=%b z=%h exp=0/0/0", busy, done, z); end
  endtask

  task automatic test_directed();
    logic [63:0] zr; int lat;
    logic        vs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] va[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb[4] = '{32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] vz[4] = '{64'hFFFFFFFF_FFFFFFEB, 64'hFFFFFFFE_00000001,
                           64'h00000000_00000001, 64'h40000000_00000000};
    for (int i = 0; i < 4; i++) begin
      run_op(vs[i], va[i], vb[i], zr, lat);
      total++; if (zr !== vz[i]) begin bad++; $display("FAIL directed_z[%0d] got=%h exp=%h", i, zr, vz[i]); end
      total++; if (lat != 33) begin bad++; $display("FAIL directed_lat[%0d] got=%0d exp=33", i, lat); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL directed_pulse[%0d] done still high", i); end
    end
  endtask

  task automatic test_random();
    logic [63:0] zr, ex; int lat;
    logic [31:0] x, y; logic s;
    logic [31:0] edges[5] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd0};
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      ex = ref32(s, x, y);
      run_op(s, x, y, zr, lat);
      total++; if (zr !== ex) begin bad++; $display("FAIL random_z s=%b a=%h b=%h got=%h exp=%h", s, x, y, zr, ex); end
      total++; if (lat != lat_exp(32, (x == 0 || y == 0))) begin
        bad++; $display("FAIL random_lat a=%h b=%h got=%0d exp=%0d", x, y, lat, lat_exp(32, (x == 0 || y == 0))); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] zr; int lat;
    logic [31:0] x, y; logic s;
    // Each new start is issued in the done cycle of the previous op.
    for (int i = 0; i < 3; i++) begin
      s = 1'($urandom); x = $urandom | 32'h1; y = $urandom | 32'h1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle[%0d] busy=%b exp=0", i, busy); end
      run_op(s, x, y, zr, lat);
      total++; if (zr !== ref32(s, x, y) || lat != 33) begin
        bad++; $display("FAIL b2b[%0d] z=%h exp=%h lat=%0d exp=33", i, zr, ref32(s, x, y), lat); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic [63:0] zprev, zfirst, ex; int ndone, first;
    zprev = z;
    ex = ref32(1'b0, 32'h01234567, 32'h00000089);
    start = 1'b1; sign = 1'b0; a = 32'h01234567; b = 32'h00000089;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; sign = 1'b1; a = 32'hFFFF0000; b = 32'h0000FFFF;
    @(posedge clk); #1;   // edge k+5
    start = 1'b0;
    ndone = 0; first = -1; zfirst = '0;
    for (int n = 6; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 20) begin
        total++; if (z !== zprev) begin bad++; $display("FAIL ignore_z_hold got=%h exp=%h", z, zprev); end
      end
      if (done) begin
        ndone++;
        if (first < 0) begin first = n; zfirst = z; end
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", ndone); end
    total++; if (first != 33) begin bad++; $display("FAIL ignore_lat got=%0d exp=33", first); end
    total++; if (zfirst !== ex) begin bad++; $display("FAIL ignore_z got=%h exp=%h", zfirst, ex); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] zr; int lat, ndone;
    run_op(1'b0, 32'd3, 32'd3, zr, lat);
    total++; if (zr !== 64'd9) begin bad++; $display("FAIL prerst_z got=%h exp=9", zr); end
    @(posedge clk); #1;
    start = 1'b1; sign = 1'b1; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_running busy=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || z !== 64'd0 || done !== 1'b0) begin
      bad++; $display("FAIL midrst_async busy=%b z=%h done=%b exp=0/0/0", busy, z, done); end
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    total++; if (ndone != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    run_op(1'b0, 32'd5, 32'd6, zr, lat);
    total++; if (zr !== 64'd30 || lat != 33) begin
      bad++; $display("FAIL postrst_op z=%h exp=1e lat=%0d exp=33", zr, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [63:0] zr; int lat;
    run_op(1'b0, 32'd7, 32'd9, zr, lat);     // leave a nonzero z behind
    @(posedge clk); #1;
    run_op(1'b0, 32'd0, 32'h1234, zr, lat);
    total++; if (zr !== 64'd0) begin bad++; $display("FAIL zero_z got=%h exp=0", zr); end
    total++; if (lat != lat_exp(32, 1'b1)) begin bad++; $display("FAIL zero_lat got=%0d exp=%0d", lat, lat_exp(32, 1'b1)); end
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFFFFFF, 32'd0, zr, lat);
    total++; if (zr !== 64'd0 || lat != lat_exp(32, 1'b1)) begin
      bad++; $display("FAIL zero_b z=%h exp=0 lat=%0d exp=%0d", zr, lat, lat_exp(32, 1'b1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_width8();
    logic [15:0] zr; int lat;
    logic [7:0] x, y; logic s;
    run_op8(1'b1, 8'h80, 8'h7F, zr, lat);
    total++; if (zr !== 16'hC080) begin bad++; $display("FAIL w8_z got=%h exp=c080", zr); end
    total++; if (lat != 9) begin bad++; $display("FAIL w8_lat got=%0d exp=9", lat); end
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      s = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      run_op8(s, x, y, zr, lat);
      total++; if (zr !== ref8(s, x, y) || lat != lat_exp(8, (x == 0 || y == 0))) begin
        bad++; $display("FAIL w8_rand s=%b a=%h b=%h z=%h exp=%h lat=%0d", s, x, y, zr, ref8(s, x, y), lat); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sign8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_zero();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
